stdin: RTL

- Simulation-only memory-mapped console input device. It is the read-side counterpart of the stdout sink.
- The host harness pushes bytes into a small FIFO. The CPU reads them with loads from a data register at STDIN_BASE_ADDR, and can poll a status register at STDIN_BASE_ADDR+8.
- The block sits on the data-memory bus next to stdout. Its read data is muxed in when `stdin_taken` is asserted.

---
 rtl/stdin_if.sv | 35 +++
 rtl/stdin.sv | 92 +++++++++
 2 files changed

// File: rtl/stdin_if.sv
// rtl/stdin_if.sv - shared constants/types and the CPU-bus/push interface of the console input device
package configurations;
    localparam logic [63:0] STDIN_BASE_ADDR = 64'h0000_0000_8000_1000;

    typedef enum logic [2:0] {
        NO_STORE     = 3'd0,
        STORE_BYTE   = 3'd1,
        STORE_HALF   = 3'd2,
        STORE_WORD   = 3'd3,
        STORE_DOUBLE = 3'd4
    } mem_store_type_t;
endpackage

interface stdin_if;
    logic [63:0]                     addr;
    logic                            mem_read;
    configurations::mem_store_type_t mem_store_type;
    logic [63:0]                     r_data;
    logic                            stdin_taken;
    logic                            push_valid;
    logic [7:0]                      push_data;
    logic                            push_ready;

    // Device side: owns the read data, the taken flag and the push handshake ready.
    modport slave (
        input  addr, mem_read, mem_store_type, push_valid, push_data,
        output r_data, stdin_taken, push_ready
    );

    // CPU and harness side.
    modport master (
        output addr, mem_read, mem_store_type, push_valid, push_data,
        input  r_data, stdin_taken, push_ready
    );
endinterface

// File: rtl/stdin.sv
// rtl/stdin.sv - memory-mapped console input FIFO with DATA and STATUS registers
module stdin #(
    parameter int          DEPTH     = 16,
    parameter logic [63:0] BASE_ADDR = configurations::STDIN_BASE_ADDR
) (
    input  logic    clock,
    input  logic    reset,
    stdin_if.slave  bus
);
    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic          overflow;
    logic          taken;

    logic [63:0] offset;
    logic        hit;
    logic        hit_data;
    logic        hit_status;
    logic        is_store;
    logic        empty;
    logic        full;
    logic        do_pop;
    logic        do_push;
    logic [63:0] status_word;

    // Unsigned subtraction folds both window bounds into one compare.
    assign offset     = bus.addr - BASE_ADDR;
    assign hit        = offset < 64'd16;
    assign hit_data   = hit && !bus.addr[3];
    assign hit_status = hit && bus.addr[3];
    assign is_store   = bus.mem_store_type != configurations::NO_STORE;

    assign empty = count == '0;
    assign full  = count == FULL_COUNT;

    // Pop and push are both judged on pre-edge occupancy, so a same-cycle pop never makes room.
    assign do_pop  = bus.mem_read && hit_data && !empty;
    assign do_push = bus.push_valid && !full;

    assign status_word = {48'b0, 8'(count), 5'b0, overflow, full, !empty};

    // Load data mux: FIFO head (or -1 when empty), status, or zero outside the window.
    always_comb begin
        bus.r_data = 64'b0;
        if (hit_data) begin
            bus.r_data = empty ? {64{1'b1}} : {56'b0, mem[head]};
        end else if (hit_status) begin
            bus.r_data = status_word;
        end
    end

    assign bus.push_ready  = !full;
    assign bus.stdin_taken = taken;

    // Byte storage; contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clock) begin
        if (reset && do_push) begin
            mem[tail] <= bus.push_data;
        end
    end

    // Pointers, occupancy, sticky overflow and the registered access flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            taken    <= 1'b0;
        end else begin
            if (do_pop) begin
                head <= head + PTR_ONE;
            end
            if (do_push) begin
                tail <= tail + PTR_ONE;
            end
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
            if (bus.push_valid && full) begin
                overflow <= 1'b1;
            end else if (is_store && hit_status) begin
                overflow <= 1'b0;
            end
            taken <= hit && (bus.mem_read || is_store);
        end
    end
endmodule
